// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Optional control-code legality check: define ALU_ARB_CTL_CHECK_EN.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTL_W-1:0]  req0_ctl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTL_W-1:0]  req1_ctl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [CTL_W-1:0]  alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic              last_grant;
  logic              owner;
  logic [CTL_W-1:0]  op_ctl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;
  logic              res_err;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              acc_port;
  logic              acc_bad;
  logic              rsp_take;
  logic [CTL_W-1:0]  acc_ctl;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;

  // Tie goes to the port that did not win last time.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  always_comb begin
    accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    acc_port = req1_ready;
    acc_ctl  = acc_port ? req1_ctl : req0_ctl;
    acc_a    = acc_port ? req1_a   : req0_a;
    acc_b    = acc_port ? req1_b   : req0_b;
    rsp_take = owner ? rsp1_ready : rsp0_ready;
  end

`ifdef ALU_ARB_CTL_CHECK_EN
  always_comb begin
    acc_bad = (acc_ctl >= CTL_W'(11)) && (acc_ctl <= CTL_W'(14));
  end
`else
  always_comb begin
    acc_bad = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = acc_bad ? RESP : EXEC;
      end
      EXEC: state_nx = RESP;
      RESP: begin
        if (rsp_take) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        req0_ready = ~rst & grant0;
        req1_ready = ~rst & grant1;
      end
      (state == RESP): begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_ctl     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res_data   <= '0;
      res_zero   <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        owner      <= acc_port;
        last_grant <= acc_port;
        if (acc_bad) begin
          res_data <= '0;
          res_zero <= 1'b1;
          res_err  <= 1'b1;
        end else begin
          op_ctl <= acc_ctl;
          op_a   <= acc_a;
          op_b   <= acc_b;
        end
      end
      if (state == EXEC) begin
        res_data <= alu_out;
        res_zero <= alu_zero;
        res_err  <= 1'b0;
      end
    end
  end

  always_comb begin
    alu_ctl  = op_ctl;
    alu_a    = op_a;
    alu_b    = op_b;
    rsp_data = res_data;
    rsp_zero = res_zero;
    rsp_err  = res_err;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small behavioural ALU.
// Covers latency, round-robin, response stall, reset mid-op, optional ctl check.
module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [CW-1:0] req0_ctl;
  logic [DW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_ready;
  logic [CW-1:0] req1_ctl;
  logic [DW-1:0] req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready;
  logic          rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero, rsp_err;
  logic [CW-1:0] alu_ctl;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic          alu_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(DW), .CTL_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      4'd0: alu_out = alu_a + alu_b;
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      4'd4: alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req0_ready"}, 32'(req0_ready), 0);
    chk({tag, ".req1_ready"}, 32'(req1_ready), 0);
    chk({tag, ".rsp0_valid"}, 32'(rsp0_valid), 0);
    chk({tag, ".rsp1_valid"}, 32'(rsp1_valid), 0);
    chk({tag, ".rsp_data"}, rsp_data, 0);
    chk({tag, ".rsp_zero"}, 32'(rsp_zero), 0);
    chk({tag, ".rsp_err"}, 32'(rsp_err), 0);
    chk({tag, ".alu_ctl"}, 32'(alu_ctl), 0);
    chk({tag, ".alu_a"}, alu_a, 0);
    chk({tag, ".alu_b"}, alu_b, 0);
  endtask

  logic [31:0] exp_data [4];
  logic        exp_own  [4];

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_ctl = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_ctl = 0; req1_a = 0; req1_b = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_all_zero("reset");

    // port 0 only: 5 + 7
    req0_valid = 1; req0_ctl = 0; req0_a = 5; req0_b = 7;
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    chk("p0.ready", 32'(req0_ready), 1);
    chk("p0.ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 0;
    #1;
    chk("p0.exec_ready", 32'(req0_ready), 0);
    chk("p0.exec_rsp", 32'(rsp0_valid), 0);
    chk("p0.alu_a", alu_a, 5);
    chk("p0.alu_b", alu_b, 7);
    tick();
    chk("p0.rsp_valid", 32'(rsp0_valid), 1);
    chk("p0.rsp1_valid", 32'(rsp1_valid), 0);
    chk("p0.data", rsp_data, 12);
    chk("p0.zero", 32'(rsp_zero), 0);
    tick();
    chk("p0.done", 32'(rsp0_valid), 0);

    // port 1 only: 9 - 9
    req1_valid = 1; req1_ctl = 1; req1_a = 9; req1_b = 9;
    #1;
    chk("p1.ready", 32'(req1_ready), 1);
    tick();
    req1_valid = 0;
    tick();
    chk("p1.rsp_valid", 32'(rsp1_valid), 1);
    chk("p1.rsp0_valid", 32'(rsp0_valid), 0);
    chk("p1.data", rsp_data, 0);
    chk("p1.zero", 32'(rsp_zero), 1);
    tick();

    // both valid continuously: 1+2=3 on port 0, 10+20=30 on port 1
    req0_valid = 1; req0_ctl = 0; req0_a = 1;  req0_b = 2;
    req1_valid = 1; req1_ctl = 0; req1_a = 10; req1_b = 20;
    exp_own[0] = 0; exp_data[0] = 3;
    exp_own[1] = 1; exp_data[1] = 30;
    exp_own[2] = 0; exp_data[2] = 3;
    exp_own[3] = 1; exp_data[3] = 30;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr%0d.ready0", i), 32'(req0_ready), 32'(!exp_own[i]));
      chk($sformatf("rr%0d.ready1", i), 32'(req1_ready), 32'(exp_own[i]));
      tick();
      chk($sformatf("rr%0d.exec_r0", i), 32'(req0_ready), 0);
      chk($sformatf("rr%0d.exec_r1", i), 32'(req1_ready), 0);
      tick();
      chk($sformatf("rr%0d.rsp0", i), 32'(rsp0_valid), 32'(!exp_own[i]));
      chk($sformatf("rr%0d.rsp1", i), 32'(rsp1_valid), 32'(exp_own[i]));
      chk($sformatf("rr%0d.data", i), rsp_data, exp_data[i]);
      chk($sformatf("rr%0d.resp_r0", i), 32'(req0_ready), 0);
      tick();
    end
    req1_valid = 0;

    // response stall: 0xF0 & 0x3C = 0x30, port 1 waiting meanwhile
    req0_ctl = 2; req0_a = 32'hF0; req0_b = 32'h3C;
    rsp0_ready = 0;
    req1_valid = 1;
    #1;
    chk("st.ready0", 32'(req0_ready), 1);
    tick();
    req0_valid = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("st%0d.rsp0", i), 32'(rsp0_valid), 1);
      chk($sformatf("st%0d.data", i), rsp_data, 32'h30);
      chk($sformatf("st%0d.r0", i), 32'(req0_ready), 0);
      chk($sformatf("st%0d.r1", i), 32'(req1_ready), 0);
      tick();
    end
    rsp0_ready = 1;
    #1;
    chk("st.hs_r1", 32'(req1_ready), 0);
    tick();
    chk("st.idle_rsp0", 32'(rsp0_valid), 0);
    chk("st.idle_r1", 32'(req1_ready), 1);
    req1_valid = 0;

    // reset during EXEC of a port 0 op
    req0_valid = 1; req0_ctl = 0; req0_a = 3; req0_b = 4;
    #1;
    chk("rs.ready0", 32'(req0_ready), 1);
    tick();
    req0_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk_all_zero("rs");
    tick();
    chk("rs.no_rsp0", 32'(rsp0_valid), 0);
    chk("rs.no_rsp1", 32'(rsp1_valid), 0);
    // port 0 must win the tie after reset: 5 | 0xA = 0xF
    req0_valid = 1; req0_ctl = 3; req0_a = 5; req0_b = 32'hA;
    req1_valid = 1;
    #1;
    chk("rs.tie_r0", 32'(req0_ready), 1);
    chk("rs.tie_r1", 32'(req1_ready), 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("rs.rsp0", 32'(rsp0_valid), 1);
    chk("rs.data", rsp_data, 32'hF);
    chk("rs.err", 32'(rsp_err), 0);
    tick();

`ifdef ALU_ARB_CTL_CHECK_EN
    // illegal code 12 on port 1 bypasses the ALU
    req1_valid = 1; req1_ctl = 12; req1_a = 1; req1_b = 2;
    #1;
    chk("ck.ready1", 32'(req1_ready), 1);
    tick();
    req1_valid = 0;
    chk("ck.rsp1", 32'(rsp1_valid), 1);
    chk("ck.err", 32'(rsp_err), 1);
    chk("ck.data", rsp_data, 0);
    chk("ck.zero", 32'(rsp_zero), 1);
    chk("ck.alu_ctl", 32'(alu_ctl), 3);
    chk("ck.alu_a", alu_a, 5);
    tick();
    // legal op clears the error flag: 8 ^ 1 = 9
    req1_valid = 1; req1_ctl = 4; req1_a = 8; req1_b = 1;
    #1;
    tick();
    req1_valid = 0;
    tick();
    chk("ck2.rsp1", 32'(rsp1_valid), 1);
    chk("ck2.err", 32'(rsp_err), 0);
    chk("ck2.data", rsp_data, 9);
    tick();
`else
    // code 12 goes to the ALU normally; model returns 0
    req1_valid = 1; req1_ctl = 12; req1_a = 1; req1_b = 2;
    #1;
    tick();
    req1_valid = 0;
    chk("nc.exec_rsp1", 32'(rsp1_valid), 0);
    chk("nc.alu_ctl", 32'(alu_ctl), 12);
    tick();
    chk("nc.rsp1", 32'(rsp1_valid), 1);
    chk("nc.err", 32'(rsp_err), 0);
    chk("nc.zero", 32'(rsp_zero), 1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
